aes_block_packer: RTL

//  Upstream feeder for the aes_128 core. Packs a byte stream (valid/ready) into 128-bit blocks.

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_byte_assembler.sv | 66 ++++++
 rtl/aes_block_packer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES block feeder: block geometry and issue FSM states.
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} issue_state_t;
endpackage

// File: rtl/aes_byte_assembler.sv
// Fill side of the packer: collects bytes MSB-first into a 128-bit block and flags completion.
module aes_byte_assembler
  import aes_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  input  logic                 take,
  output logic                 blk_avail,
  output logic [AES_BLK_W-1:0] blk_data,
  output logic                 blk_last,
  output logic [3:0]           blk_pad,
  output logic                 full,
  output logic                 fill_busy
);

  logic [3:0]           fcnt;
  logic [AES_BLK_W-1:0] buf_q;
  logic [AES_BLK_W-1:0] buf_nxt;
  logic                 full_q;
  logic                 last_q;
  logic [3:0]           pad_q;
  logic                 cmp_now;

  // The first byte of a block clears the buffer, so unwritten tail bytes are already zero-padded.
  always_comb begin
    buf_nxt = (fcnt == 4'd0) ? '0 : buf_q;
    buf_nxt[AES_BLK_W-1-DATA_W*fcnt -: DATA_W] = in_data;
    cmp_now = in_vld && ((fcnt == 4'd15) || in_last);
  end

  // A block completing this cycle is offered directly so it can reach hold on the same edge.
  assign blk_avail = full_q || cmp_now;
  assign blk_data  = full_q ? buf_q  : buf_nxt;
  assign blk_last  = full_q ? last_q : in_last;
  assign blk_pad   = full_q ? pad_q  : 4'd15 - fcnt;
  assign full      = full_q;
  assign fill_busy = full_q || (fcnt != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt   <= 4'd0;
      buf_q  <= '0;
      full_q <= 1'b0;
      last_q <= 1'b0;
      pad_q  <= 4'd0;
    end else begin
      if (in_vld) begin
        fcnt  <= cmp_now ? 4'd0 : fcnt + 4'd1;
        buf_q <= buf_nxt;
      end
      if (cmp_now && !take) begin
        full_q <= 1'b1;
        last_q <= in_last;
        pad_q  <= 4'd15 - fcnt;
      end else if (take) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Byte-stream to AES block feeder: fill buffer, hold buffer and an issue FSM with watchdog.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [AES_BLK_W-1:0] blk_data,
  output logic                 blk_start,
  output logic                 blk_last,
  output logic [3:0]           blk_pad,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  issue_state_t         state, state_nxt;
  logic                 rdy_en;
  logic                 xfer;
  logic                 take;
  logic                 load;
  logic                 timeout_hit;
  logic                 wd_expire;
  logic [WD_W-1:0]      wd;

  logic                 fa_avail;
  logic [AES_BLK_W-1:0] fa_data;
  logic                 fa_last;
  logic [3:0]           fa_pad;
  logic                 fa_full;
  logic                 fa_busy;

  logic                 hold_vld;
  logic [AES_BLK_W-1:0] hold_data;
  logic                 hold_last;
  logic [3:0]           hold_pad;

  assign s_ready = rdy_en && !fa_full;
  assign xfer    = s_valid && s_ready;

  aes_byte_assembler #(.DATA_W(8)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (xfer),
    .in_data   (s_data),
    .in_last   (s_last),
    .take      (take),
    .blk_avail (fa_avail),
    .blk_data  (fa_data),
    .blk_last  (fa_last),
    .blk_pad   (fa_pad),
    .full      (fa_full),
    .fill_busy (fa_busy)
  );

  // Hold is free when empty or when IDLE is moving it into the core this same edge.
  assign take      = fa_avail && (!hold_vld || (state == IDLE));
  assign wd_expire = (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (hold_vld) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        if (core_done) begin
          state_nxt = GAP;
        end else if (wd_expire) begin
          state_nxt   = GAP;
          timeout_hit = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rdy_en      <= 1'b0;
      wd          <= '0;
      err_timeout <= 1'b0;
      hold_vld    <= 1'b0;
      hold_data   <= '0;
      hold_last   <= 1'b0;
      hold_pad    <= 4'd0;
      blk_data    <= '0;
      blk_last    <= 1'b0;
      blk_pad     <= 4'd0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      wd     <= (state == ISSUE) ? wd + WD_W'(1) : '0;
      if (timeout_hit) err_timeout <= 1'b1;
      if (take) begin
        hold_vld  <= 1'b1;
        hold_data <= fa_data;
        hold_last <= fa_last;
        hold_pad  <= fa_pad;
      end else if (load) begin
        hold_vld <= 1'b0;
      end
      if (load) begin
        blk_data <= hold_data;
        blk_last <= hold_last;
        blk_pad  <= hold_pad;
      end
    end
  end

  assign blk_start = (state == ISSUE);
  assign busy      = fa_busy || hold_vld || (state != IDLE);

endmodule
